// File: rtl/adc_cal_sequencer_if.sv
// Control, status and ADC/DTU calibration signals of the ADC calibration sequencer.
// The master side requests runs and models the ADCs; the slave side is the sequencer.
interface adc_cal_sequencer_if;
   logic       cal_req;
   logic       abort;
   logic [1:0] ch_sel;
   logic [1:0] AdcCalBusyIn;
   logic [1:0] AdcCal;
   logic       DtuSyncMode;
   logic       DtuFlush;
   logic       seq_busy;
   logic       seq_done;
   logic       seq_err;
   logic [1:0] err_code;

   modport master (
      output cal_req, abort, ch_sel, AdcCalBusyIn,
      input  AdcCal, DtuSyncMode, DtuFlush, seq_busy, seq_done, seq_err, err_code
   );

   modport slave (
      input  cal_req, abort, ch_sel, AdcCalBusyIn,
      output AdcCal, DtuSyncMode, DtuFlush, seq_busy, seq_done, seq_err, err_code
   );
endinterface

// File: rtl/adc_cal_sequencer.sv
// ADC calibration sequencer: DTU sync mode, calibration pulse, bounded tracking of the
// returned busy flags, closing DTU flush, and done/error reporting.
module adc_cal_sequencer #(
   parameter int CAL_PULSE_LEN = 8,
   parameter int RISE_WAIT     = 16,
   parameter int FALL_TIMEOUT  = 4096,
   parameter int FLUSH_LEN     = 4,
   parameter int CNT_W         = 13
) (
   input logic                clock,
   input logic                rst,
   adc_cal_sequencer_if.slave bus
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SYNC      = 3'd1;
   localparam logic [2:0] ST_PULSE     = 3'd2;
   localparam logic [2:0] ST_WAIT_RISE = 3'd3;
   localparam logic [2:0] ST_WAIT_FALL = 3'd4;
   localparam logic [2:0] ST_FLUSH     = 3'd5;
   localparam logic [2:0] ST_DONE      = 3'd6;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_NO_RISE = 2'b01;
   localparam logic [1:0] ERR_STUCK   = 2'b10;
   localparam logic [1:0] ERR_ABORT   = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(CAL_PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] RISE_LOAD  = CNT_W'(RISE_WAIT - 1);
   localparam logic [CNT_W-1:0] FALL_LOAD  = CNT_W'(FALL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_LEN - 1);

   logic [2:0]       state_r;
   logic [2:0]       nextState_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] nextCount_s;
   logic [CNT_W-1:0] countDec_s;
   logic             countZero_s;
   logic [1:0]       chLatch_r;
   logic [1:0]       nextCh_s;
   logic [1:0]       busySync1_r;
   logic [1:0]       busySync2_r;
   logic [1:0]       busySel_s;
   logic             anyBusy_s;
   logic             abortHit_s;
   logic             nextErr_s;
   logic [1:0]       nextCode_s;

   logic [1:0]       adcCalNext_s;
   logic             syncModeNext_s;
   logic             flushNext_s;
   logic             doneNext_s;
   logic             busyNext_s;

   logic [1:0]       adcCal_r;
   logic             dtuSyncMode_r;
   logic             dtuFlush_r;
   logic             seqBusy_r;
   logic             seqDone_r;
   logic             seqErr_r;
   logic [1:0]       errCode_r;

   // Busy is only meaningful on the channels chosen for this run
   assign busySel_s   = busySync2_r & chLatch_r;
   assign anyBusy_s   = |busySel_s;
   assign countZero_s = (count_r == CNT_ZERO);
   assign countDec_s  = count_r - CNT_ONE;
   assign abortHit_s  = bus.abort & ((state_r == ST_SYNC) | (state_r == ST_PULSE) |
                                     (state_r == ST_WAIT_RISE) | (state_r == ST_WAIT_FALL));

   // Next-state, counter, channel latch and error bookkeeping
   always_comb begin
      nextState_s = state_r;
      nextCount_s = count_r;
      nextCh_s    = chLatch_r;
      nextErr_s   = seqErr_r;
      nextCode_s  = errCode_r;
      if (abortHit_s) begin
         nextState_s = ST_FLUSH;
         nextCount_s = FLUSH_LOAD;
         nextErr_s   = 1'b1;
         nextCode_s  = ERR_ABORT;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.cal_req && (bus.ch_sel != 2'b00)) begin
                  nextState_s = ST_SYNC;
                  nextCount_s = CNT_ZERO;
                  nextCh_s    = bus.ch_sel;
                  nextErr_s   = 1'b0;
                  nextCode_s  = ERR_NONE;
               end else begin
                  nextState_s = ST_IDLE;
               end
            end
            ST_SYNC: begin
               nextState_s = ST_PULSE;
               nextCount_s = PULSE_LOAD;
            end
            ST_PULSE: begin
               if (countZero_s) begin
                  nextState_s = ST_WAIT_RISE;
                  nextCount_s = RISE_LOAD;
               end else begin
                  nextCount_s = countDec_s;
               end
            end
            // A rise seen on the expiry cycle still wins over the timeout
            ST_WAIT_RISE: begin
               if (anyBusy_s) begin
                  nextState_s = ST_WAIT_FALL;
                  nextCount_s = FALL_LOAD;
               end else if (countZero_s) begin
                  nextState_s = ST_FLUSH;
                  nextCount_s = FLUSH_LOAD;
                  nextErr_s   = 1'b1;
                  nextCode_s  = ERR_NO_RISE;
               end else begin
                  nextCount_s = countDec_s;
               end
            end
            ST_WAIT_FALL: begin
               if (!anyBusy_s) begin
                  nextState_s = ST_FLUSH;
                  nextCount_s = FLUSH_LOAD;
               end else if (countZero_s) begin
                  nextState_s = ST_FLUSH;
                  nextCount_s = FLUSH_LOAD;
                  nextErr_s   = 1'b1;
                  nextCode_s  = ERR_STUCK;
               end else begin
                  nextCount_s = countDec_s;
               end
            end
            ST_FLUSH: begin
               if (countZero_s) begin
                  nextState_s = ST_DONE;
                  nextCount_s = CNT_ZERO;
               end else begin
                  nextCount_s = countDec_s;
               end
            end
            ST_DONE: begin
               nextState_s = ST_IDLE;
               nextCount_s = CNT_ZERO;
            end
            default: begin
               nextState_s = ST_IDLE;
               nextCount_s = CNT_ZERO;
               nextCh_s    = 2'b00;
            end
         endcase
      end
   end

   // Output values belonging to the state entered on the coming edge
   always_comb begin
      adcCalNext_s   = 2'b00;
      syncModeNext_s = 1'b0;
      flushNext_s    = 1'b0;
      doneNext_s     = 1'b0;
      case (nextState_s)
         ST_SYNC: begin
            syncModeNext_s = 1'b1;
         end
         ST_PULSE: begin
            adcCalNext_s   = nextCh_s;
            syncModeNext_s = 1'b1;
         end
         ST_WAIT_RISE, ST_WAIT_FALL: begin
            syncModeNext_s = 1'b1;
         end
         ST_FLUSH: begin
            syncModeNext_s = 1'b1;
            flushNext_s    = 1'b1;
         end
         ST_DONE: begin
            doneNext_s = 1'b1;
         end
         default: begin
            adcCalNext_s   = 2'b00;
            syncModeNext_s = 1'b0;
         end
      endcase
   end

   assign busyNext_s = (nextState_s != ST_IDLE);

   // State, counter, busy synchronisers and registered outputs
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         count_r       <= CNT_ZERO;
         chLatch_r     <= 2'b00;
         busySync1_r   <= 2'b00;
         busySync2_r   <= 2'b00;
         adcCal_r      <= 2'b00;
         dtuSyncMode_r <= 1'b0;
         dtuFlush_r    <= 1'b0;
         seqBusy_r     <= 1'b0;
         seqDone_r     <= 1'b0;
         seqErr_r      <= 1'b0;
         errCode_r     <= ERR_NONE;
      end else begin
         state_r       <= nextState_s;
         count_r       <= nextCount_s;
         chLatch_r     <= nextCh_s;
         busySync1_r   <= bus.AdcCalBusyIn;
         busySync2_r   <= busySync1_r;
         adcCal_r      <= adcCalNext_s;
         dtuSyncMode_r <= syncModeNext_s;
         dtuFlush_r    <= flushNext_s;
         seqBusy_r     <= busyNext_s;
         seqDone_r     <= doneNext_s;
         seqErr_r      <= nextErr_s;
         errCode_r     <= nextCode_s;
      end
   end

   assign bus.AdcCal      = adcCal_r;
   assign bus.DtuSyncMode = dtuSyncMode_r;
   assign bus.DtuFlush    = dtuFlush_r;
   assign bus.seq_busy    = seqBusy_r;
   assign bus.seq_done    = seqDone_r;
   assign bus.seq_err     = seqErr_r;
   assign bus.err_code    = errCode_r;

endmodule

// File: tb/tb_adc_cal_sequencer.sv
// Bench for adc_cal_sequencer: directed scenarios plus randomized runs compared cycle by
// cycle with an event-timeline model built from the sequencing rules.
module tb_adc_cal_sequencer;
   localparam int MAXC = 4400;

   logic       clock;
   logic       rst;
   int         checks;
   int         errors;
   logic [1:0] busyPat [0:MAXC-1];
   logic [8:0] obs [0:MAXC-1];
   int         abortAt;
   int         extraReqAt;
   logic [1:0] extraCh;
   int         calCnt0, calCnt1, calFirst, flushFirst, flushCnt, doneCnt, doneAt;

   adc_cal_sequencer_if bus();
   adc_cal_sequencer dut (.clock(clock), .rst(rst), .bus(bus));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Packed view: {AdcCal[1:0], DtuSyncMode, DtuFlush, seq_busy, seq_done, seq_err, err_code[1:0]}
   function automatic logic [8:0] obsNow();
      return {bus.AdcCal, bus.DtuSyncMode, bus.DtuFlush, bus.seq_busy, bus.seq_done, bus.seq_err, bus.err_code};
   endfunction

   task automatic fillPat(input logic [1:0] v);
      for (int k = 0; k < MAXC; k++) busyPat[k] = v;
   endtask

   task automatic setBit(input int b, input int from, input int to);
      for (int k = from; k <= to; k++) busyPat[k][b] = 1'b1;
   endtask

   // Edge 0 is the edge that accepts cal_req; obs[k] holds outputs after edge k,
   // busyPat[k] is the busy input presented to edge k.
   task automatic runSeq(input logic [1:0] ch, input int len);
      @(negedge clock);
      bus.cal_req = 1'b1;
      bus.ch_sel = ch;
      bus.abort = 1'b0;
      bus.AdcCalBusyIn = busyPat[0];
      for (int k = 0; k < len; k++) begin
         @(negedge clock);
         obs[k] = obsNow();
         bus.cal_req = (k + 1 == extraReqAt);
         bus.ch_sel = (k + 1 == extraReqAt) ? extraCh : ch;
         bus.abort = (k + 1 == abortAt);
         bus.AdcCalBusyIn = busyPat[k + 1];
      end
      bus.cal_req = 1'b0;
      bus.abort = 1'b0;
      bus.AdcCalBusyIn = 2'b00;
   endtask

   task automatic summarize(input int len);
      calCnt0 = 0; calCnt1 = 0; calFirst = -1; flushFirst = -1; flushCnt = 0; doneCnt = 0; doneAt = -1;
      for (int k = 0; k < len; k++) begin
         if (obs[k][7]) calCnt0++;
         if (obs[k][8]) calCnt1++;
         if ((obs[k][8:7] != 2'b00) && (calFirst < 0)) calFirst = k;
         if (obs[k][5]) begin flushCnt++; if (flushFirst < 0) flushFirst = k; end
         if (obs[k][3]) begin doneCnt++; doneAt = k; end
      end
   endtask

   // Timeline model: pulse occupies edges 1..8, rise window is edges 10..25, the
   // synchroniser makes the input of edge e-2 visible at edge e, abort wins on edges 1..f.
   function automatic void model(input logic [1:0] ch, input int abortEdge, output int f, output logic [1:0] code);
      int w;
      w = -1; f = -1; code = 2'b00;
      for (int e = 10; e <= 25; e++) if ((busyPat[e-2] & ch) != 2'b00) begin w = e; break; end
      if (w < 0) begin
         f = 25; code = 2'b01;
      end else begin
         for (int e = w + 1; e <= w + 4096; e++) if ((busyPat[e-2] & ch) == 2'b00) begin f = e; break; end
         if (f < 0) begin f = w + 4096; code = 2'b10; end
      end
      if (abortEdge >= 1 && abortEdge <= f) begin f = abortEdge; code = 2'b11; end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (obsNow() !== 9'd0) begin errors++; $display("FAIL reset_outputs got %b expected %b", obsNow(), 9'd0); end
      rst = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (obsNow() !== 9'd0) begin errors++; $display("FAIL idle_after_reset got %b expected %b", obsNow(), 9'd0); end
   endtask

   task automatic test_nominal();
      abortAt = -1; extraReqAt = -1;
      fillPat(2'b00); setBit(0, 12, 111);
      runSeq(2'b01, 125); summarize(125);
      checks++; if (calFirst !== 1) begin errors++; $display("FAIL nominal_cal_rise got %0d expected %0d", calFirst, 1); end
      checks++; if (calCnt0 !== 8) begin errors++; $display("FAIL nominal_cal0_len got %0d expected %0d", calCnt0, 8); end
      checks++; if (calCnt1 !== 0) begin errors++; $display("FAIL nominal_cal1_len got %0d expected %0d", calCnt1, 0); end
      checks++; if (flushFirst !== 114) begin errors++; $display("FAIL nominal_flush_start got %0d expected %0d", flushFirst, 114); end
      checks++; if (flushCnt !== 4) begin errors++; $display("FAIL nominal_flush_len got %0d expected %0d", flushCnt, 4); end
      checks++; if (doneCnt !== 1 || doneAt !== 118) begin errors++; $display("FAIL nominal_done got cnt=%0d at=%0d expected cnt=1 at=118", doneCnt, doneAt); end
      checks++; if (obs[124][4:0] !== 5'b00000) begin errors++; $display("FAIL nominal_final_status got %b expected %b", obs[124][4:0], 5'b00000); end
      checks++; if (obs[50][6] !== 1'b1) begin errors++; $display("FAIL nominal_syncmode_wait got %b expected %b", obs[50][6], 1'b1); end
   endtask

   task automatic test_no_rise();
      abortAt = -1; extraReqAt = -1;
      fillPat(2'b00);
      runSeq(2'b10, 35); summarize(35);
      checks++; if (calCnt1 !== 8 || calCnt0 !== 0) begin errors++; $display("FAIL norise_cal got %0d/%0d expected 8/0", calCnt1, calCnt0); end
      checks++; if (obs[24][2:0] !== 3'b000) begin errors++; $display("FAIL norise_before_timeout got %b expected %b", obs[24][2:0], 3'b000); end
      checks++; if (obs[25][2:0] !== 3'b101) begin errors++; $display("FAIL norise_err got %b expected %b", obs[25][2:0], 3'b101); end
      checks++; if (flushFirst !== 25 || flushCnt !== 4) begin errors++; $display("FAIL norise_flush got start=%0d len=%0d expected 25/4", flushFirst, flushCnt); end
      checks++; if (doneCnt !== 1 || doneAt !== 29) begin errors++; $display("FAIL norise_done got cnt=%0d at=%0d expected 1/29", doneCnt, doneAt); end
   endtask

   task automatic test_stuck_high();
      abortAt = -1; extraReqAt = -1;
      fillPat(2'b11);
      runSeq(2'b11, 4115); summarize(4115);
      checks++; if (calCnt0 !== 8 || calCnt1 !== 8) begin errors++; $display("FAIL stuck_cal got %0d/%0d expected 8/8", calCnt0, calCnt1); end
      checks++; if (obs[4105][2:0] !== 3'b000) begin errors++; $display("FAIL stuck_before_timeout got %b expected %b", obs[4105][2:0], 3'b000); end
      checks++; if (obs[4106][2:0] !== 3'b110) begin errors++; $display("FAIL stuck_err got %b expected %b", obs[4106][2:0], 3'b110); end
      checks++; if (flushFirst !== 4106 || flushCnt !== 4) begin errors++; $display("FAIL stuck_flush got start=%0d len=%0d expected 4106/4", flushFirst, flushCnt); end
      checks++; if (doneCnt !== 1 || doneAt !== 4110) begin errors++; $display("FAIL stuck_done got cnt=%0d at=%0d expected 1/4110", doneCnt, doneAt); end
      checks++; if (bus.seq_err !== 1'b1) begin errors++; $display("FAIL stuck_err_sticky got %b expected %b", bus.seq_err, 1'b1); end
   endtask

   task automatic test_abort();
      abortAt = 5; extraReqAt = -1;
      fillPat(2'b00);
      runSeq(2'b11, 15); summarize(15);
      abortAt = -1;
      checks++; if (obs[0][2:0] !== 3'b000) begin errors++; $display("FAIL abort_req_clears_err got %b expected %b", obs[0][2:0], 3'b000); end
      checks++; if (calCnt0 !== 4 || calCnt1 !== 4) begin errors++; $display("FAIL abort_cal_len got %0d/%0d expected 4/4", calCnt0, calCnt1); end
      checks++; if (obs[5][8:7] !== 2'b00 || obs[5][2:0] !== 3'b111) begin errors++; $display("FAIL abort_edge got %b expected cal=00 err=111", obs[5]); end
      checks++; if (flushFirst !== 5 || flushCnt !== 4) begin errors++; $display("FAIL abort_flush got start=%0d len=%0d expected 5/4", flushFirst, flushCnt); end
      checks++; if (doneCnt !== 1 || doneAt !== 9) begin errors++; $display("FAIL abort_done got cnt=%0d at=%0d expected 1/9", doneCnt, doneAt); end
   endtask

   task automatic test_ignored_requests();
      @(negedge clock);
      bus.cal_req = 1'b1; bus.ch_sel = 2'b00;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         if (k == 2) bus.cal_req = 1'b0;
         checks++; if (obsNow() !== 9'b000000111) begin errors++; $display("FAIL zero_chsel_ignored k=%0d got %b expected %b", k, obsNow(), 9'b000000111); end
      end
      abortAt = -1; extraReqAt = 50; extraCh = 2'b11;
      fillPat(2'b00); setBit(0, 12, 111); setBit(1, 40, 200);
      runSeq(2'b01, 125); summarize(125);
      extraReqAt = -1;
      checks++; if (calCnt0 !== 8 || calCnt1 !== 0) begin errors++; $display("FAIL busyreq_cal got %0d/%0d expected 8/0", calCnt0, calCnt1); end
      checks++; if (flushFirst !== 114) begin errors++; $display("FAIL busyreq_flush_start got %0d expected %0d", flushFirst, 114); end
      checks++; if (doneCnt !== 1 || doneAt !== 118) begin errors++; $display("FAIL busyreq_done got cnt=%0d at=%0d expected 1/118", doneCnt, doneAt); end
      checks++; if (obs[124][4:0] !== 5'b00000) begin errors++; $display("FAIL busyreq_final got %b expected %b", obs[124][4:0], 5'b00000); end
   endtask

   task automatic test_async_reset();
      abortAt = -1; extraReqAt = -1;
      fillPat(2'b11);
      runSeq(2'b11, 30);
      checks++; if (obs[29][8:3] !== 6'b001010) begin errors++; $display("FAIL midrun_wait_fall got %b expected %b", obs[29][8:3], 6'b001010); end
      #1 rst = 1'b1;
      #2;
      checks++; if (obsNow() !== 9'd0) begin errors++; $display("FAIL async_reset_outputs got %b expected %b", obsNow(), 9'd0); end
      @(negedge clock);
      rst = 1'b0;
      fillPat(2'b00); setBit(0, 12, 111);
      runSeq(2'b01, 125); summarize(125);
      checks++; if (obs[0][6:4] !== 3'b101 || obs[0][8:7] !== 2'b00) begin errors++; $display("FAIL restart_sync got %b expected sync=1 flush=0 busy=1 cal=00", obs[0]); end
      checks++; if (calFirst !== 1 || calCnt0 !== 8) begin errors++; $display("FAIL restart_cal got first=%0d len=%0d expected 1/8", calFirst, calCnt0); end
      checks++; if (flushFirst !== 114 || doneAt !== 118) begin errors++; $display("FAIL restart_flush_done got %0d/%0d expected 114/118", flushFirst, doneAt); end
   endtask

   task automatic test_random();
      logic [1:0] ch;
      logic [1:0] code;
      logic [8:0] exp;
      int f, len, s, l;
      for (int it = 0; it < 30; it++) begin
         ch = 2'($urandom_range(1, 3));
         for (int k = 0; k < MAXC; k++) busyPat[k] = (k < 8) ? 2'($urandom) : (2'($urandom) & ~ch);
         for (int b = 0; b < 2; b++) begin
            if (ch[b] && ($urandom_range(0, 5) != 0)) begin
               s = int'($urandom_range(8, 30));
               l = int'($urandom_range(1, 60));
               setBit(b, s, s + l - 1);
            end
         end
         abortAt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : -1;
         model(ch, abortAt, f, code);
         extraReqAt = int'($urandom_range(1, f + 5));
         extraCh = 2'($urandom);
         len = f + 8;
         runSeq(ch, len);
         for (int k = 0; k < len; k++) begin
            exp = 9'd0;
            exp[8:7] = (k >= 1 && k <= 8 && k < f) ? ch : 2'b00;
            exp[6] = (k <= f + 3);
            exp[5] = (k >= f && k <= f + 3);
            exp[4] = (k <= f + 4);
            exp[3] = (k == f + 4);
            exp[2] = (k >= f && code != 2'b00);
            exp[1:0] = (k >= f) ? code : 2'b00;
            checks++; if (obs[k] !== exp) begin errors++; $display("FAIL random_cycle it=%0d ch=%b k=%0d got %b expected %b", it, ch, k, obs[k], exp); end
         end
      end
      abortAt = -1; extraReqAt = -1;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      bus.cal_req = 1'b0; bus.abort = 1'b0; bus.ch_sel = 2'b00; bus.AdcCalBusyIn = 2'b00;
      abortAt = -1; extraReqAt = -1; extraCh = 2'b00;
      test_reset();
      test_nominal();
      test_no_rise();
      test_stuck_high();
      test_abort();
      test_ignored_requests();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
